note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
// - Song player; drives the frequency/amplitude inputs of the sine SignalGenerator.
// - Steps through a song table of {frequency, beats} entries at the 32 kHz sample clock.
// - Holds each note for its duration, then zeroes amplitude for a release gap so the generator's amplitude smoothing separates repeated notes.
// - Supports start, stop, looping and an end-of-song pulse.
// PARAMETERS
// - SONG_LEN        64    table depth; index width = $clog2(SONG_LEN)
// - TICKS_PER_BEAT  4000  CLK_32KHz cycles per beat (125 ms); must be > GAP_TICKS
// - GAP_TICKS       320   release cycles at the end of each note, amplitude 0
// - NOTE_AMPLITUDE  200   amplitude driven during a sounding note
// PORTS
// - CLK_32KHz        in   1   sample clock, single clock domain
// - reset            in   1   synchronous, active-high
// - start            in   1   level-sampled; begins playback from index 0 when IDLE
// - stop             in   1   abort playback; priority over start
// - loop_en          in   1   restart at index 0 on song end instead of stopping
// - outputFrequency  out  14  Hz, 0 = rest; to SignalGenerator inputFrequency
// - outputAmplitude  out  8   to SignalGenerator inputAmplitude
// - noteIndex        out  IW  table index currently playing
// - noteStart        out  1   1-cycle pulse on entry to NOTE
// - busy             out  1   high in every state except IDLE
// - songDone         out  1   1-cycle pulse on a non-looping end of song or on stop
// BEHAVIOUR
// - Reset sets all outputs to 0 and state to IDLE; reset mid-song aborts immediately.
// - Table entry: {freq[13:0], beats[3:0]}; beats==0 is the end marker.
// - ROM read latency is 1 cycle; address = noteIndex register.
// - FSM IDLE->ADDR->LOAD->NOTE->GAP->ADDR...
//   IDLE: on start && !stop -> ADDR; noteIndex<=0; busy<=1.
//   ADDR: wait 1 cycle for ROM data -> LOAD.
//   LOAD, beats!=0: latch freq; amp<=(freq==0)?0:NOTE_AMPLITUDE; cnt<=beats*TICKS_PER_BEAT-GAP_TICKS-1 -> NOTE.
//   LOAD, beats==0: end of song (see End of song below).
//   NOTE: drive outputs; noteStart high on the first cycle; at cnt==0 -> GAP with amp<=0, freq held, cnt<=GAP_TICKS-1.
//   GAP: at cnt==0, if noteIndex==SONG_LEN-1 -> end of song; else noteIndex+1 -> ADDR.
// - Start to first note: start sampled at edge E; NOTE outputs are valid after edge E+2.
// - Per-note period = beats*TICKS_PER_BEAT + 2 cycles (ADDR and LOAD; amp stays 0, freq held).
// - End of song:
//   loop_en=1 and noteIndex!=0: noteIndex<=0 -> ADDR.
//   Otherwise: freq<=0, amp<=0, songDone pulse, busy<=0 -> IDLE.
//   An end marker at index 0 means an empty song; it never loops.
// - stop in any non-IDLE state: next edge -> IDLE; freq and amp <=0; songDone pulse.
//   stop in IDLE has no effect.
// - start while busy is ignored. start and stop together in IDLE -> stays IDLE.
// - Duration counter width = $clog2(15*TICKS_PER_BEAT); no wrap, because cnt only reloads in LOAD and GAP.
// - No arithmetic on freq; it passes through unmodified.
// STRUCTURE
// - music_box_pkg:
//   typedef enum seq_state_t {IDLE,ADDR,LOAD,NOTE,GAP}
//   typedef struct packed song_entry_t {freq[13:0], beats[3:0]}
//   FREQ_W=14, AMP_W=8
// - Sub-module song_rom #(SONG_LEN): registered-output ROM of song_entry_t, initialised from a generated .mif/.hex.
// - FSM and counters live in note_sequencer.
// TESTING (sim params TICKS_PER_BEAT=10, GAP_TICKS=2, SONG_LEN=4)
// - Table {440,1},{0,2},{880,1},{0,0}, start pulse at edge E:
//   freq=440, amp=200 for 8 cycles from E+2; then amp=0 for 4 cycles.
//   Rest: freq=0, amp=0, 18+2 cycles. freq=880 note follows.
//   songDone pulses once; busy falls; outputs 0.
// - Same table, loop_en=1: after the 880 gap, noteIndex returns to 0 and 440 replays.
//   songDone never pulses.
// - Full table, no marker {100,1}x4: after index 3's GAP the song ends.
//   noteIndex never exceeds 3.
// - stop asserted mid-NOTE (amp=200): next cycle amp=0, freq=0, busy=0, songDone=1 for 1 cycle.
//   start together with stop in IDLE is ignored.
// - reset asserted mid-GAP: all outputs 0 next cycle.
//   start pulsed while busy: noteIndex sequence unchanged.
//   Table {0,0} at index 0 with loop_en=1: IDLE after LOAD, one songDone.
// - noteStart: exactly one pulse per table entry played.

Source files
------------

// File: rtl/music_box_pkg.sv
// rtl/music_box_pkg.sv - shared types and widths for the song player
package music_box_pkg;
    localparam int FREQ_W  = 14;
    localparam int AMP_W   = 8;
    localparam int BEATS_W = 4;

    typedef enum logic [2:0] {IDLE, ADDR, LOAD, NOTE, GAP} seq_state_t;

    typedef struct packed {
        logic [FREQ_W-1:0]  freq;
        logic [BEATS_W-1:0] beats;
    } song_entry_t;

    localparam int ENTRY_W = FREQ_W + BEATS_W;

    function automatic song_entry_t mk_entry(input logic [FREQ_W-1:0] freq,
                                             input logic [BEATS_W-1:0] beats);
        song_entry_t e;
        e.freq  = freq;
        e.beats = beats;
        return e;
    endfunction
endpackage

// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - control and tone-output bundle between player and its host
interface note_sequencer_if
    import music_box_pkg::*;
#(
    parameter int IW = 6
);
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [FREQ_W-1:0] outputFrequency;
    logic [AMP_W-1:0]  outputAmplitude;
    logic [IW-1:0]     noteIndex;
    logic              noteStart;
    logic              busy;
    logic              songDone;

    modport master (
        output start, stop, loop_en,
        input  outputFrequency, outputAmplitude, noteIndex, noteStart, busy, songDone
    );

    modport slave (
        input  start, stop, loop_en,
        output outputFrequency, outputAmplitude, noteIndex, noteStart, busy, songDone
    );
endinterface

// File: rtl/song_rom.sv
// rtl/song_rom.sv - registered-output song table, contents supplied as a generated parameter
module song_rom
    import music_box_pkg::*;
#(
    parameter int                          SONG_LEN  = 64,
    parameter logic [SONG_LEN*ENTRY_W-1:0] SONG_INIT = '0
) (
    input  logic                        clk_i,
    input  logic [$clog2(SONG_LEN)-1:0] addr_i,
    output song_entry_t                 data_o
);
    song_entry_t data_q;

    always_ff @(posedge clk_i) begin
        data_q <= song_entry_t'(SONG_INIT[int'(addr_i)*ENTRY_W +: ENTRY_W]);
    end

    assign data_o = data_q;
endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - steps through the song table and drives the sine generator's freq/amp
module note_sequencer
    import music_box_pkg::*;
#(
    parameter int                          SONG_LEN       = 64,
    parameter int                          TICKS_PER_BEAT = 4000,
    parameter int                          GAP_TICKS      = 320,
    parameter int                          NOTE_AMPLITUDE = 200,
    parameter logic [SONG_LEN*ENTRY_W-1:0] SONG_INIT      = '0
) (
    input  logic             CLK_32KHz,
    input  logic             reset,
    note_sequencer_if.slave  bus
);
    localparam int IW    = $clog2(SONG_LEN);
    localparam int CNT_W = $clog2(15*TICKS_PER_BEAT);

    seq_state_t        state_q;
    logic [IW-1:0]     idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [FREQ_W-1:0] freq_q;
    logic [AMP_W-1:0]  amp_q;
    logic              note_start_q;
    logic              busy_q;
    logic              song_done_q;
    song_entry_t       rom_q;

    song_rom #(.SONG_LEN(SONG_LEN), .SONG_INIT(SONG_INIT)) u_rom (
        .clk_i  (CLK_32KHz),
        .addr_i (idx_q),
        .data_o (rom_q)
    );

    always_ff @(posedge CLK_32KHz) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            freq_q       <= '0;
            amp_q        <= '0;
            note_start_q <= 1'b0;
            busy_q       <= 1'b0;
            song_done_q  <= 1'b0;
        end else begin
            note_start_q <= 1'b0;
            song_done_q  <= 1'b0;
            if (state_q != IDLE && bus.stop) begin
                state_q     <= IDLE;
                freq_q      <= '0;
                amp_q       <= '0;
                busy_q      <= 1'b0;
                song_done_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start && !bus.stop) begin
                            state_q <= ADDR;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ADDR: state_q <= LOAD;
                    LOAD: begin
                        if (rom_q.beats != '0) begin
                            freq_q       <= rom_q.freq;
                            amp_q        <= (rom_q.freq == '0) ? '0 : AMP_W'(NOTE_AMPLITUDE);
                            cnt_q        <= CNT_W'(int'(rom_q.beats) * TICKS_PER_BEAT - GAP_TICKS - 1);
                            note_start_q <= 1'b1;
                            state_q      <= NOTE;
                        // An end marker at index 0 is an empty song and must never loop
                        end else if (bus.loop_en && idx_q != '0) begin
                            idx_q   <= '0;
                            state_q <= ADDR;
                        end else begin
                            freq_q      <= '0;
                            amp_q       <= '0;
                            busy_q      <= 1'b0;
                            song_done_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                    NOTE: begin
                        if (cnt_q == '0) begin
                            amp_q   <= '0;
                            cnt_q   <= CNT_W'(GAP_TICKS - 1);
                            state_q <= GAP;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (idx_q != IW'(SONG_LEN-1)) begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ADDR;
                        end else if (bus.loop_en && idx_q != '0) begin
                            idx_q   <= '0;
                            state_q <= ADDR;
                        end else begin
                            freq_q      <= '0;
                            amp_q       <= '0;
                            busy_q      <= 1'b0;
                            song_done_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.outputFrequency = freq_q;
    assign bus.outputAmplitude = amp_q;
    assign bus.noteIndex       = idx_q;
    assign bus.noteStart       = note_start_q;
    assign bus.busy            = busy_q;
    assign bus.songDone        = song_done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - table-driven bench for note_sequencer with three small song tables
module tb_note_sequencer;
    import music_box_pkg::*;

    localparam int SL  = 4;
    localparam int TPB = 10;
    localparam int GT  = 2;
    localparam int AMP = 200;
    localparam int IW  = 2;

    localparam logic [SL*ENTRY_W-1:0] SONG_A = {mk_entry(14'd0, 4'd0),   mk_entry(14'd880, 4'd1),
                                                mk_entry(14'd0, 4'd2),   mk_entry(14'd440, 4'd1)};
    localparam logic [SL*ENTRY_W-1:0] SONG_B = {mk_entry(14'd100, 4'd1), mk_entry(14'd100, 4'd1),
                                                mk_entry(14'd100, 4'd1), mk_entry(14'd100, 4'd1)};
    localparam logic [SL*ENTRY_W-1:0] SONG_C = {mk_entry(14'd0, 4'd0),   mk_entry(14'd0, 4'd0),
                                                mk_entry(14'd0, 4'd0),   mk_entry(14'd0, 4'd0)};

    typedef struct packed {
        logic [13:0] freq;
        logic [7:0]  amp;
        logic [1:0]  idx;
        logic        ns;
        logic        busy;
        logic        done;
    } obs_t;

    typedef struct {
        int   k;
        logic rst;
        logic start;
        logic stop;
        obs_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_v = '0;
    logic [2:0] stop_v  = '0;
    logic [2:0] loop_v  = '0;
    obs_t       obs [3];
    vec_t       vecs[$];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    note_sequencer_if #(.IW(IW)) if_a ();
    note_sequencer_if #(.IW(IW)) if_b ();
    note_sequencer_if #(.IW(IW)) if_c ();

    note_sequencer #(.SONG_LEN(SL), .TICKS_PER_BEAT(TPB), .GAP_TICKS(GT), .NOTE_AMPLITUDE(AMP),
                     .SONG_INIT(SONG_A)) dut_a (.CLK_32KHz(clk), .reset(rst), .bus(if_a));
    note_sequencer #(.SONG_LEN(SL), .TICKS_PER_BEAT(TPB), .GAP_TICKS(GT), .NOTE_AMPLITUDE(AMP),
                     .SONG_INIT(SONG_B)) dut_b (.CLK_32KHz(clk), .reset(rst), .bus(if_b));
    note_sequencer #(.SONG_LEN(SL), .TICKS_PER_BEAT(TPB), .GAP_TICKS(GT), .NOTE_AMPLITUDE(AMP),
                     .SONG_INIT(SONG_C)) dut_c (.CLK_32KHz(clk), .reset(rst), .bus(if_c));

    assign if_a.start = start_v[0];  assign if_a.stop = stop_v[0];  assign if_a.loop_en = loop_v[0];
    assign if_b.start = start_v[1];  assign if_b.stop = stop_v[1];  assign if_b.loop_en = loop_v[1];
    assign if_c.start = start_v[2];  assign if_c.stop = stop_v[2];  assign if_c.loop_en = loop_v[2];

    assign obs[0] = {if_a.outputFrequency, if_a.outputAmplitude, if_a.noteIndex, if_a.noteStart, if_a.busy, if_a.songDone};
    assign obs[1] = {if_b.outputFrequency, if_b.outputAmplitude, if_b.noteIndex, if_b.noteStart, if_b.busy, if_b.songDone};
    assign obs[2] = {if_c.outputFrequency, if_c.outputAmplitude, if_c.noteIndex, if_c.noteStart, if_c.busy, if_c.songDone};

    task automatic add(input int k, input logic r, input logic s, input logic p,
                       input int f, input int a, input int i, input logic n, input logic b, input logic d);
        vec_t v;
        v.k = k; v.rst = r; v.start = s; v.stop = p;
        v.exp = {14'(f), 8'(a), 2'(i), n, b, d};
        vecs.push_back(v);
    endtask

    task automatic check_obs(input string nm, input int k, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got freq=%0d amp=%0d idx=%0d ns=%0b busy=%0b done=%0b required freq=%0d amp=%0d idx=%0d ns=%0b busy=%0b done=%0b",
                     nm, k, got.freq, got.amp, got.idx, got.ns, got.busy, got.done,
                     exp.freq, exp.amp, exp.idx, exp.ns, exp.busy, exp.done);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", nm, got, exp);
        end
    endtask

    task automatic run_group(input string nm, input int d, input int lo, input int hi, input logic lp,
                             input int exp_ns, input int exp_done);
        int p;
        int ns_n;
        int dn_n;
        logic hit;
        p = lo; ns_n = 0; dn_n = 0;
        loop_v[d] = lp;
        for (int k = 0; k <= vecs[hi].k; k++) begin
            hit = (p <= hi) && (vecs[p].k == k);
            rst       = hit ? vecs[p].rst   : 1'b0;
            start_v[d] = hit ? vecs[p].start : 1'b0;
            stop_v[d]  = hit ? vecs[p].stop  : 1'b0;
            @(posedge clk);
            #1;
            ns_n += int'(obs[d].ns);
            dn_n += int'(obs[d].done);
            if (hit) begin
                check_obs(nm, k, obs[d], vecs[p].exp);
                p++;
            end
        end
        rst = 1'b0; start_v[d] = 1'b0; stop_v[d] = 1'b0; loop_v[d] = 1'b0;
        check_int({nm, " noteStart pulses"}, ns_n, exp_ns);
        check_int({nm, " songDone pulses"}, dn_n, exp_done);
    endtask

    initial begin
        int g0, g1, g2, g3, g4, g5;
        // Table A, no loop; start re-pulsed at k=20 while busy
        g0 = vecs.size();
        add(0, 0,1,0,   0,  0,0,0,1,0);  add(1, 0,0,0,   0,  0,0,0,1,0);
        add(2, 0,0,0, 440,200,0,1,1,0);  add(3, 0,0,0, 440,200,0,0,1,0);
        add(9, 0,0,0, 440,200,0,0,1,0);  add(10,0,0,0, 440,  0,0,0,1,0);
        add(13,0,0,0, 440,  0,1,0,1,0);  add(14,0,0,0,   0,  0,1,1,1,0);
        add(20,0,1,0,   0,  0,1,0,1,0);  add(31,0,0,0,   0,  0,1,0,1,0);
        add(32,0,0,0,   0,  0,1,0,1,0);  add(35,0,0,0,   0,  0,2,0,1,0);
        add(36,0,0,0, 880,200,2,1,1,0);  add(43,0,0,0, 880,200,2,0,1,0);
        add(44,0,0,0, 880,  0,2,0,1,0);  add(47,0,0,0, 880,  0,3,0,1,0);
        add(48,0,0,0,   0,  0,3,0,0,1);  add(49,0,0,0,   0,  0,3,0,0,0);
        // Table A looping, then stop mid-note, then start+stop together in IDLE
        g1 = vecs.size();
        add(0, 0,1,0,   0,  0,0,0,1,0);  add(2, 0,0,0, 440,200,0,1,1,0);
        add(36,0,0,0, 880,200,2,1,1,0);  add(47,0,0,0, 880,  0,3,0,1,0);
        add(48,0,0,0, 880,  0,0,0,1,0);  add(49,0,0,0, 880,  0,0,0,1,0);
        add(50,0,0,0, 440,200,0,1,1,0);  add(53,0,0,1,   0,  0,0,0,0,1);
        add(54,0,0,0,   0,  0,0,0,0,0);  add(55,0,1,1,   0,  0,0,0,0,0);
        add(56,0,0,0,   0,  0,0,0,0,0);
        // Table B: full table without marker ends after index 3's gap
        g2 = vecs.size();
        add(0, 0,1,0,   0,  0,0,0,1,0);  add(2, 0,0,0, 100,200,0,1,1,0);
        add(12,0,0,0, 100,  0,1,0,1,0);  add(14,0,0,0, 100,200,1,1,1,0);
        add(26,0,0,0, 100,200,2,1,1,0);  add(38,0,0,0, 100,200,3,1,1,0);
        add(47,0,0,0, 100,  0,3,0,1,0);  add(48,0,0,0,   0,  0,3,0,0,1);
        add(49,0,0,0,   0,  0,3,0,0,0);
        // Table B: reset during the first gap
        g3 = vecs.size();
        add(0, 0,1,0,   0,  0,0,0,1,0);  add(10,0,0,0, 100,  0,0,0,1,0);
        add(11,1,0,0,   0,  0,0,0,0,0);  add(12,0,0,0,   0,  0,0,0,0,0);
        add(13,0,0,0,   0,  0,0,0,0,0);
        // Table C: empty song with loop_en never loops
        g4 = vecs.size();
        add(0, 0,1,0,   0,  0,0,0,1,0);  add(1, 0,0,0,   0,  0,0,0,1,0);
        add(2, 0,0,0,   0,  0,0,0,0,1);  add(3, 0,0,0,   0,  0,0,0,0,0);
        add(5, 0,0,0,   0,  0,0,0,0,0);
        g5 = vecs.size();

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_obs("reset_a", 0, obs[0], '0);
        check_obs("reset_b", 0, obs[1], '0);
        check_obs("reset_c", 0, obs[2], '0);
        rst = 1'b0;

        run_group("song_a",      0, g0, g1-1, 1'b0, 3, 1);
        run_group("song_a_loop", 0, g1, g2-1, 1'b1, 4, 1);
        run_group("song_b_full", 1, g2, g3-1, 1'b0, 4, 1);
        run_group("song_b_rst",  1, g3, g4-1, 1'b0, 1, 0);
        run_group("song_c_empty",2, g4, g5-1, 1'b1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
